// File: rtl/z80_bus_arbiter_pkg.sv
// Shared types and helpers for the Z80 multi-master bus arbiter.
// Optional feature macro used by the arbiter: Z80_ARB_ACK_TIMEOUT_EN.
package z80_arb_pkg;

    typedef enum logic [2:0] {
        CPU_OWN,
        REQ_CPU,
        EXT_OWN,
        HANDOFF,
        RELEASE
    } arb_state_t;

    localparam int ACK_TIMEOUT_DEFAULT = 255;

    // One-hot to binary index; OR-reduction form because the input is one-hot by construction.
    function automatic logic [3:0] onehot_to_idx(input logic [15:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/z80_bus_arbiter_if.sv
// Bus-side signal bundle of the arbiter: requests, BUSRQ/BUSAK handshake, grant outputs.
// slave = arbiter side, master = requesters/CPU side.
interface z80_bus_arbiter_if #(
    parameter int MASTER_QTY = 2
);
    localparam int MSEL_W = (MASTER_QTY > 1) ? $clog2(MASTER_QTY) : 1;

    logic [MASTER_QTY-1:0] req;
    logic                  busak_n;
    logic                  busrq_n;
    logic [MASTER_QTY-1:0] gnt;
    logic [MSEL_W-1:0]     msel;
    logic                  owner_valid;
    logic                  ack_err;

    modport slave (
        input  req,
        input  busak_n,
        output busrq_n,
        output gnt,
        output msel,
        output owner_valid,
        output ack_err
    );

    modport master (
        output req,
        output busak_n,
        input  busrq_n,
        input  gnt,
        input  msel,
        input  owner_valid,
        input  ack_err
    );

endinterface

// File: rtl/z80_bus_arbiter_picker.sv
// arb_picker: combinational winner select among external masters (bit 0, the CPU, is masked).
// ROUND_ROBIN=0: lowest index wins. ROUND_ROBIN=1: search starts just after ptr_i, wrapping to 1.
module arb_picker
    import z80_arb_pkg::*;
#(
    parameter int MASTER_QTY  = 2,
    parameter int ROUND_ROBIN = 1,
    localparam int MSEL_W     = (MASTER_QTY > 1) ? $clog2(MASTER_QTY) : 1
) (
    input  logic [MASTER_QTY-1:0] req_i,
    input  logic [MSEL_W-1:0]     ptr_i,
    output logic                  valid_o,
    output logic [MASTER_QTY-1:0] win_oh_o,
    output logic [MSEL_W-1:0]     win_idx_o
);

    // Number of search slots (external masters); at least one to keep arrays legal.
    localparam int NC = (MASTER_QTY > 1) ? MASTER_QTY - 1 : 1;

    logic [15:0] req_pad;
    logic [3:0]  cand_idx [NC];
    logic [NC-1:0] cand_hit;
    logic [15:0] win_oh16;
    logic        valid;

    assign req_pad = 16'(req_i) & ~16'd1;

    // Slot gi holds the master index examined gi-th in search order.
    for (genvar gi = 0; gi < NC; gi++) begin : g_cand
        logic [3:0] raw;
        assign raw = (ROUND_ROBIN != 0) ? 4'(ptr_i) + 4'(gi + 1) : 4'(gi + 1);
        assign cand_idx[gi] = (raw > 4'(MASTER_QTY - 1)) ? raw - 4'(MASTER_QTY - 1) : raw;
        assign cand_hit[gi] = req_pad[cand_idx[gi]];
    end

    // First requesting slot in search order wins.
    always_comb begin
        win_oh16 = '0;
        valid    = 1'b0;
        for (int i = 0; i < NC; i++) begin
            if (!valid && cand_hit[i]) begin
                valid              = 1'b1;
                win_oh16[cand_idx[i]] = 1'b1;
            end
        end
    end

    assign valid_o   = valid;
    assign win_idx_o = MSEL_W'(onehot_to_idx(win_oh16));
    assign win_oh_o  = valid ? (MASTER_QTY'(1) << win_idx_o) : '0;

endmodule

// File: rtl/z80_bus_arbiter.sv
// z80_bus_arbiter: hands the shared Z80 bus between the CPU (master 0, default owner)
// and external masters via BUSRQ/BUSAK. All outputs are registered.
// Optional feature macro: Z80_ARB_ACK_TIMEOUT_EN (bounded wait for busak_n, sticky ack_err).
module z80_bus_arbiter
    import z80_arb_pkg::*;
#(
    parameter int MASTER_QTY  = 2,
    parameter int ROUND_ROBIN = 1,
    parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input logic              clk,
    input logic              rst,
    z80_bus_arbiter_if.slave bus
);

    localparam int MSEL_W = (MASTER_QTY > 1) ? $clog2(MASTER_QTY) : 1;

    arb_state_t            state_q;
    logic [MASTER_QTY-1:0] gnt_q;
    logic [MSEL_W-1:0]     msel_q;
    logic [MSEL_W-1:0]     ptr_q;
    logic                  busrq_n_q;
    logic                  ext_req_d;
    logic                  ack_timeout_d;
    logic                  ack_err_o;

    logic                  pick_valid;
    logic [MASTER_QTY-1:0] pick_oh;
    logic [MSEL_W-1:0]     pick_idx;

    // Any external request; bit 0 is the CPU and never asks for the bus.
    assign ext_req_d = |(bus.req & ~MASTER_QTY'(1));

    arb_picker #(
        .MASTER_QTY  (MASTER_QTY),
        .ROUND_ROBIN (ROUND_ROBIN)
    ) u_picker (
        .req_i     (bus.req),
        .ptr_i     (ptr_q),
        .valid_o   (pick_valid),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx)
    );

`ifdef Z80_ARB_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             ack_err_q;

    assign ack_timeout_d = (state_q == REQ_CPU) && bus.busak_n &&
                           (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    // Count cycles spent waiting for busak_n; cleared whenever not waiting.
    always_ff @(posedge clk) begin
        if (rst || state_q != REQ_CPU || !bus.busak_n) begin
            cnt_q <= '0;
        end else if (!ack_timeout_d) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Sticky acknowledge-timeout flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_err_q <= 1'b0;
        end else if (ack_timeout_d) begin
            ack_err_q <= 1'b1;
        end
    end

    assign ack_err_o = ack_err_q;
`else
    assign ack_timeout_d = 1'b0;
    assign ack_err_o     = 1'b0;
`endif

    // Ownership FSM with registered grant, msel and busrq_n.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CPU_OWN;
            gnt_q     <= MASTER_QTY'(1);
            msel_q    <= '0;
            ptr_q     <= '0;
            busrq_n_q <= 1'b1;
        end else begin
            case (state_q)
                CPU_OWN: begin
                    if (ext_req_d) begin
                        state_q   <= REQ_CPU;
                        gnt_q     <= '0;
                        busrq_n_q <= 1'b0;
                    end
                end
                REQ_CPU: begin
                    if (!bus.busak_n) begin
                        // Winner is taken from the requests present when the CPU lets go.
                        if (pick_valid) begin
                            state_q <= EXT_OWN;
                            gnt_q   <= pick_oh;
                            msel_q  <= pick_idx;
                            ptr_q   <= pick_idx;
                        end else begin
                            state_q   <= RELEASE;
                            busrq_n_q <= 1'b1;
                        end
                    end else if (ack_timeout_d) begin
                        state_q   <= RELEASE;
                        busrq_n_q <= 1'b1;
                    end
                end
                EXT_OWN: begin
                    // No preemption: tenure ends only when the owner drops its request.
                    if (!bus.req[msel_q]) begin
                        state_q <= HANDOFF;
                        gnt_q   <= '0;
                    end
                end
                HANDOFF: begin
                    if (pick_valid) begin
                        state_q <= EXT_OWN;
                        gnt_q   <= pick_oh;
                        msel_q  <= pick_idx;
                        ptr_q   <= pick_idx;
                    end else begin
                        state_q   <= RELEASE;
                        busrq_n_q <= 1'b1;
                    end
                end
                RELEASE: begin
                    if (bus.busak_n) begin
                        state_q <= CPU_OWN;
                        gnt_q   <= MASTER_QTY'(1);
                        msel_q  <= '0;
                    end
                end
                default: begin
                    state_q   <= CPU_OWN;
                    gnt_q     <= MASTER_QTY'(1);
                    msel_q    <= '0;
                    busrq_n_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.busrq_n     = busrq_n_q;
    assign bus.gnt         = gnt_q;
    assign bus.msel        = msel_q;
    assign bus.owner_valid = |gnt_q;
    assign bus.ack_err     = ack_err_o;

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed testbench for z80_bus_arbiter: a 2-master instance plus 4-master
// round-robin and fixed-priority instances sharing clock and reset.
module tb_z80_bus_arbiter;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    z80_bus_arbiter_if #(.MASTER_QTY(2)) bus2   ();
    z80_bus_arbiter_if #(.MASTER_QTY(4)) bus_rr ();
    z80_bus_arbiter_if #(.MASTER_QTY(4)) bus_fx ();

    z80_bus_arbiter #(.MASTER_QTY(2), .ROUND_ROBIN(1), .ACK_TIMEOUT(16)) u_dut2 (
        .clk (clk), .rst (rst), .bus (bus2)
    );
    z80_bus_arbiter #(.MASTER_QTY(4), .ROUND_ROBIN(1)) u_dut_rr (
        .clk (clk), .rst (rst), .bus (bus_rr)
    );
    z80_bus_arbiter #(.MASTER_QTY(4), .ROUND_ROBIN(0)) u_dut_fx (
        .clk (clk), .rst (rst), .bus (bus_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus2.req = '0;   bus2.busak_n = 1'b1;
        bus_rr.req = '0; bus_rr.busak_n = 1'b1;
        bus_fx.req = '0; bus_fx.busak_n = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (bus2.gnt !== 2'b01 || bus2.msel !== 1'b0 || bus2.busrq_n !== 1'b1 ||
            bus2.owner_valid !== 1'b1 || bus2.ack_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset2: got gnt=%b msel=%b busrq_n=%b ov=%b err=%b want 01 0 1 1 0",
                     bus2.gnt, bus2.msel, bus2.busrq_n, bus2.owner_valid, bus2.ack_err);
        end
        vectors++;
        if (bus_rr.gnt !== 4'b0001 || bus_rr.msel !== 2'd0 || bus_rr.busrq_n !== 1'b1 ||
            bus_rr.owner_valid !== 1'b1 || bus_rr.ack_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rr: got gnt=%b msel=%0d busrq_n=%b ov=%b err=%b want 0001 0 1 1 0",
                     bus_rr.gnt, bus_rr.msel, bus_rr.busrq_n, bus_rr.owner_valid, bus_rr.ack_err);
        end
        vectors++;
        if (bus_fx.gnt !== 4'b0001 || bus_fx.msel !== 2'd0 || bus_fx.busrq_n !== 1'b1 ||
            bus_fx.owner_valid !== 1'b1 || bus_fx.ack_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_fx: got gnt=%b msel=%0d busrq_n=%b ov=%b err=%b want 0001 0 1 1 0",
                     bus_fx.gnt, bus_fx.msel, bus_fx.busrq_n, bus_fx.owner_valid, bus_fx.ack_err);
        end
        $display("test_reset: done");
    endtask

    task automatic test_single();
        bus2.req = 2'b10;
        tick();
        vectors++;
        if (bus2.busrq_n !== 1'b0 || bus2.gnt !== 2'b00 || bus2.owner_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_req: got busrq_n=%b gnt=%b ov=%b want 0 00 0",
                     bus2.busrq_n, bus2.gnt, bus2.owner_valid);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus2.gnt !== 2'b00 || bus2.busrq_n !== 1'b0) begin
                miscompares++;
                $display("FAIL single_wait[%0d]: got gnt=%b busrq_n=%b want 00 0",
                         i, bus2.gnt, bus2.busrq_n);
            end
        end
        bus2.busak_n = 1'b0;
        tick();
        vectors++;
        if (bus2.gnt !== 2'b10 || bus2.msel !== 1'b1 || bus2.busrq_n !== 1'b0 ||
            bus2.owner_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL single_grant: got gnt=%b msel=%b busrq_n=%b ov=%b want 10 1 0 1",
                     bus2.gnt, bus2.msel, bus2.busrq_n, bus2.owner_valid);
        end
        bus2.req = 2'b00;
        tick();
        vectors++;
        if (bus2.gnt !== 2'b00 || bus2.busrq_n !== 1'b0 || bus2.msel !== 1'b1) begin
            miscompares++;
            $display("FAIL single_handoff: got gnt=%b busrq_n=%b msel=%b want 00 0 1",
                     bus2.gnt, bus2.busrq_n, bus2.msel);
        end
        tick();
        vectors++;
        if (bus2.busrq_n !== 1'b1 || bus2.gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL single_release: got busrq_n=%b gnt=%b want 1 00",
                     bus2.busrq_n, bus2.gnt);
        end
        bus2.busak_n = 1'b1;
        tick();
        vectors++;
        if (bus2.gnt !== 2'b01 || bus2.msel !== 1'b0 || bus2.busrq_n !== 1'b1) begin
            miscompares++;
            $display("FAIL single_back: got gnt=%b msel=%b busrq_n=%b want 01 0 1",
                     bus2.gnt, bus2.msel, bus2.busrq_n);
        end
        $display("test_single: done");
    endtask

    task automatic test_round_robin();
        int         order [4] = '{1, 2, 3, 1};
        logic [3:0] exp;
        bus_rr.req = 4'b1110;
        tick();
        vectors++;
        if (bus_rr.busrq_n !== 1'b0 || bus_rr.gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL rr_req: got busrq_n=%b gnt=%b want 0 0000", bus_rr.busrq_n, bus_rr.gnt);
        end
        bus_rr.busak_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp = 4'b0001 << order[i];
            vectors++;
            if (bus_rr.gnt !== exp || bus_rr.msel !== 2'(order[i]) || bus_rr.busrq_n !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_grant[%0d]: got gnt=%b msel=%0d busrq_n=%b want %b %0d 0",
                         i, bus_rr.gnt, bus_rr.msel, bus_rr.busrq_n, exp, order[i]);
            end
            $display("rr grant %0d -> master %0d", i, bus_rr.msel);
            bus_rr.req = 4'b1110 & ~exp;
            tick();
            vectors++;
            if (bus_rr.gnt !== 4'b0000 || bus_rr.busrq_n !== 1'b0 || bus_rr.msel !== 2'(order[i])) begin
                miscompares++;
                $display("FAIL rr_handoff[%0d]: got gnt=%b busrq_n=%b msel=%0d want 0000 0 %0d",
                         i, bus_rr.gnt, bus_rr.busrq_n, bus_rr.msel, order[i]);
            end
            bus_rr.req = (i == 3) ? 4'b0000 : 4'b1110;
        end
        tick();
        vectors++;
        if (bus_rr.busrq_n !== 1'b1 || bus_rr.gnt !== 4'b0000) begin
            miscompares++;
            $display("FAIL rr_release: got busrq_n=%b gnt=%b want 1 0000", bus_rr.busrq_n, bus_rr.gnt);
        end
        bus_rr.busak_n = 1'b1;
        tick();
        vectors++;
        if (bus_rr.gnt !== 4'b0001 || bus_rr.msel !== 2'd0) begin
            miscompares++;
            $display("FAIL rr_back: got gnt=%b msel=%0d want 0001 0", bus_rr.gnt, bus_rr.msel);
        end
        $display("test_round_robin: done");
    endtask

    task automatic test_fixed();
        bus_fx.req = 4'b1110;
        tick();
        bus_fx.busak_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vectors++;
            if (bus_fx.gnt !== 4'b0010 || bus_fx.msel !== 2'd1 || bus_fx.busrq_n !== 1'b0) begin
                miscompares++;
                $display("FAIL fx_grant[%0d]: got gnt=%b msel=%0d busrq_n=%b want 0010 1 0",
                         i, bus_fx.gnt, bus_fx.msel, bus_fx.busrq_n);
            end
            $display("fx grant %0d -> master %0d", i, bus_fx.msel);
            bus_fx.req = 4'b1100;
            tick();
            vectors++;
            if (bus_fx.gnt !== 4'b0000 || bus_fx.busrq_n !== 1'b0) begin
                miscompares++;
                $display("FAIL fx_handoff[%0d]: got gnt=%b busrq_n=%b want 0000 0",
                         i, bus_fx.gnt, bus_fx.busrq_n);
            end
            bus_fx.req = (i == 3) ? 4'b0000 : 4'b1110;
        end
        tick();
        bus_fx.busak_n = 1'b1;
        tick();
        vectors++;
        if (bus_fx.gnt !== 4'b0001 || bus_fx.busrq_n !== 1'b1) begin
            miscompares++;
            $display("FAIL fx_back: got gnt=%b busrq_n=%b want 0001 1", bus_fx.gnt, bus_fx.busrq_n);
        end
        $display("test_fixed: done");
    endtask

    task automatic test_pulse();
        bus2.req = 2'b10;
        tick();
        bus2.req = 2'b00;
        tick();
        bus2.busak_n = 1'b0;
        tick();
        vectors++;
        if (bus2.gnt !== 2'b00 || bus2.busrq_n !== 1'b1 || bus2.owner_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_release: got gnt=%b busrq_n=%b ov=%b want 00 1 0",
                     bus2.gnt, bus2.busrq_n, bus2.owner_valid);
        end
        bus2.busak_n = 1'b1;
        tick();
        vectors++;
        if (bus2.gnt !== 2'b01 || bus2.msel !== 1'b0) begin
            miscompares++;
            $display("FAIL pulse_back: got gnt=%b msel=%b want 01 0", bus2.gnt, bus2.msel);
        end
        $display("test_pulse: done");
    endtask

    task automatic test_reset_mid();
        bus2.req = 2'b10;
        tick();
        bus2.busak_n = 1'b0;
        tick();
        vectors++;
        if (bus2.gnt !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_owned: got gnt=%b want 10", bus2.gnt);
        end
        rst = 1'b1;
        tick();
        vectors++;
        if (bus2.gnt !== 2'b01 || bus2.msel !== 1'b0 || bus2.busrq_n !== 1'b1 ||
            bus2.ack_err !== 1'b0 || bus2.owner_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_reset: got gnt=%b msel=%b busrq_n=%b err=%b ov=%b want 01 0 1 0 1",
                     bus2.gnt, bus2.msel, bus2.busrq_n, bus2.ack_err, bus2.owner_valid);
        end
        bus2.req = 2'b00;
        bus2.busak_n = 1'b1;
        rst = 1'b0;
        tick();
        $display("test_reset_mid: done");
    endtask

`ifdef Z80_ARB_ACK_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        bus2.req = 2'b10;
        bus2.busak_n = 1'b1;
        tick();
        n = 0;
        while (bus2.busrq_n === 1'b0 && n < 40) begin
            tick();
            n++;
        end
        vectors++;
        if (n !== 16) begin
            miscompares++;
            $display("FAIL timeout_len: got %0d cycles want 16", n);
        end
        vectors++;
        if (bus2.ack_err !== 1'b1 || bus2.gnt !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_err: got err=%b gnt=%b want 1 00", bus2.ack_err, bus2.gnt);
        end
        tick();
        vectors++;
        if (bus2.gnt !== 2'b01 || bus2.ack_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_cpu: got gnt=%b err=%b want 01 1", bus2.gnt, bus2.ack_err);
        end
        tick();
        vectors++;
        if (bus2.busrq_n !== 1'b0 || bus2.ack_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_retry: got busrq_n=%b err=%b want 0 1", bus2.busrq_n, bus2.ack_err);
        end
        bus2.req = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if (bus2.ack_err !== 1'b0 || bus2.busrq_n !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_clear: got err=%b busrq_n=%b want 0 1", bus2.ack_err, bus2.busrq_n);
        end
        tick();
        $display("test_timeout: done");
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_fixed();
        test_pulse();
        test_reset_mid();
`ifdef Z80_ARB_ACK_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
